// File: rtl/arith_pkg.sv
// Shared arithmetic-library types and helpers: divider FSM states, default width
// and a magnitude helper usable for any operand width up to ABS_MAX_W bits.
package arith_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;
    localparam int ABS_MAX_W         = 64;
    localparam int ABS_IDX_W         = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // Caller zero-extends a width-bit operand and truncates the result back.
    function automatic logic [ABS_MAX_W-1:0] abs_val(
        input logic [ABS_MAX_W-1:0] value,
        input logic                 is_signed,
        input int unsigned          width
    );
        logic [ABS_MAX_W-1:0] mask;
        logic [ABS_IDX_W-1:0] msb_idx;
        logic                 neg;
        mask    = {ABS_MAX_W{1'b1}} >> (ABS_MAX_W - width);
        msb_idx = ABS_IDX_W'(width - 32'd1);
        neg     = is_signed & value[msb_idx];
        if (neg) begin
            abs_val = (~value + 64'd1) & mask;
        end else begin
            abs_val = value & mask;
        end
    endfunction

endpackage

// File: rtl/seq_divider_16bit_if.sv
// Operand/result handshake bundle for seq_divider_16bit; the divider is the
// slave, the operand producer / result consumer is the master.
interface seq_divider_16bit_if
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             signed_overflow;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, is_signed, out_ready,
        input  in_ready, out_valid, quotient, remainder,
               div_by_zero, signed_overflow, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, out_ready,
        output in_ready, out_valid, quotient, remainder,
               div_by_zero, signed_overflow, busy
    );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference or restore.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvs_mag_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] shifted_s;
    logic [WIDTH+1:0] diff_s;

    // The extra top bit of diff_s is the borrow, i.e. the sign of the trial result.
    always_comb begin
        shifted_s = {rem_i, dvd_bit_i};
        diff_s    = shifted_s - {2'b00, dvs_mag_i};
        if (diff_s[WIDTH+1] == 1'b0) begin
            rem_o   = diff_s[WIDTH:0];
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted_s[WIDTH:0];
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed/unsigned per op.
// Optional build macro DIV_EARLY_TERM_EN: skip iteration when |dividend| < |divisor|.
module seq_divider_16bit
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    seq_divider_16bit_if.slave  bus
);

    localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_mag_q, dvs_mag_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] q_res_q, q_res_d;
    logic [WIDTH-1:0] r_res_q, r_res_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic [WIDTH:0]   rem_step_s;
    logic             q_bit_s;

    assign dvd_mag_s = WIDTH'(abs_val(ABS_MAX_W'(bus.dividend), bus.is_signed, WIDTH));
    assign dvs_mag_s = WIDTH'(abs_val(ABS_MAX_W'(bus.divisor),  bus.is_signed, WIDTH));

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (quo_q[WIDTH-1]),
        .dvs_mag_i (dvs_mag_q),
        .rem_o     (rem_step_s),
        .q_bit_o   (q_bit_s)
    );

    // Next-state and datapath update; quo_q starts as the dividend magnitude and
    // is shifted out into the step while quotient bits shift in from the right.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_mag_d  = dvs_mag_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        ovf_pend_d = ovf_pend_q;
        q_res_d    = q_res_q;
        r_res_d    = r_res_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    rem_d      = {(WIDTH+1){1'b0}};
                    quo_d      = dvd_mag_s;
                    dvs_mag_d  = dvs_mag_s;
                    cnt_d      = {CNT_W{1'b0}};
                    q_neg_d    = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    r_neg_d    = bus.is_signed & bus.dividend[WIDTH-1];
                    ovf_pend_d = bus.is_signed & (bus.dividend == MOST_NEG) & (bus.divisor == W_ONES);
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    if (bus.divisor == W_ZERO) begin
                        state_d = DONE;
                        q_res_d = W_ONES;
                        r_res_d = bus.dividend;
                        dbz_d   = 1'b1;
                    end
`ifdef DIV_EARLY_TERM_EN
                    else if (dvd_mag_s < dvs_mag_s) begin
                        state_d = DONE;
                        q_res_d = W_ZERO;
                        r_res_d = bus.dividend;
                    end
`endif
                    else begin
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d = rem_step_s;
                quo_d = {quo_q[WIDTH-2:0], q_bit_s};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIXUP;
                end else begin
                    state_d = CALC;
                end
            end
            FIXUP: begin
                q_res_d = q_neg_q ? (~quo_q + W_ONE) : quo_q;
                r_res_d = r_neg_q ? (~rem_q[WIDTH-1:0] + W_ONE) : rem_q[WIDTH-1:0];
                ovf_d   = ovf_pend_q;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == CALC) || (state_d == FIXUP);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Iteration datapath, result registers and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= {CNT_W{1'b0}};
            rem_q      <= {(WIDTH+1){1'b0}};
            quo_q      <= W_ZERO;
            dvs_mag_q  <= W_ZERO;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            q_res_q    <= W_ZERO;
            r_res_q    <= W_ZERO;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_mag_q  <= dvs_mag_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            ovf_pend_q <= ovf_pend_d;
            q_res_q    <= q_res_d;
            r_res_q    <= r_res_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    // Handshake/status outputs registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.busy            = busy_q;
    assign bus.quotient        = q_res_q;
    assign bus.remainder       = r_res_q;
    assign bus.div_by_zero     = dbz_q;
    assign bus.signed_overflow = ovf_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed self-checking bench for seq_divider_16bit (hand-computed vectors).
module tb_seq_divider_16bit;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider_16bit_if #(.WIDTH(W)) bus ();

    seq_divider_16bit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (b == 16'h0000) begin
            return 1;
        end
`ifdef DIV_EARLY_TERM_EN
        begin
            logic [W-1:0] ma;
            logic [W-1:0] mb;
            ma = (s && a[W-1]) ? (~a + 16'h0001) : a;
            mb = (s && b[W-1]) ? (~b + 16'h0001) : b;
            if (ma < mb) begin
                return 1;
            end
        end
`else
        if (s && a == 16'h0000) begin
            return 18;
        end
`endif
        return 18;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.is_signed = s;
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid is seen.
    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) bus.in_valid = 1'b0;
        end while (!bus.out_valid && lat < 200);
        check_eq({tag, "_outvalid"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_eq({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_ready_set"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edz, input logic eov);
        int lat;
        start_op(a, b, s);
        wait_result(tag, lat);
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat(a, b, s)));
        check_eq({tag, "_quo"}, 32'(bus.quotient), 32'(eq));
        check_eq({tag, "_rem"}, 32'(bus.remainder), 32'(er));
        check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(edz));
        check_eq({tag, "_ovf"}, 32'(bus.signed_overflow), 32'(eov));
        release_result(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_dbz"}, 32'(bus.div_by_zero), 32'd0);
        check_eq({tag, "_ovf"}, 32'(bus.signed_overflow), 32'd0);
        check_eq({tag, "_quo"}, 32'(bus.quotient), 32'd0);
        check_eq({tag, "_rem"}, 32'(bus.remainder), 32'd0);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.dividend  = 16'h0000;
        bus.divisor   = 16'h0000;
        bus.is_signed = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;

        do_op("u1000_7",  16'h03E8, 16'h0007, 1'b0, 16'h008E, 16'h0006, 1'b0, 1'b0);
        do_op("s_m7_2",   16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        do_op("s_7_m2",   16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
        do_op("s_dz",     16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
        do_op("u_dz",     16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
        do_op("s_ovf",    16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1);
        do_op("u_8000",   16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0);

        // Backpressure: 255 / 16 = 15 r 15, held while a new request is offered.
        start_op(16'h00FF, 16'h0010, 1'b0);
        wait_result("bp", lat);
        check_eq("bp_lat", 32'(lat), 32'd18);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 16'h0064;
        bus.divisor  = 16'h0003;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_hold_inrdy", 32'(bus.in_ready), 32'd0);
            check_eq("bp_hold_quo", 32'(bus.quotient), 32'h000F);
            check_eq("bp_hold_rem", 32'(bus.remainder), 32'h000F);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        release_result("bp");
        @(posedge clk);
        #1;
        check_eq("bp_no_start", 32'(bus.busy), 32'd0);
        check_eq("bp_quo_kept", 32'(bus.quotient), 32'h000F);

        // Asynchronous reset in the middle of CALC.
        start_op(16'h03E8, 16'h0007, 1'b0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("midrst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;

        do_op("u100_10", 16'h0064, 16'h000A, 1'b0, 16'h000A, 16'h0000, 1'b0, 1'b0);
        do_op("u5_9",    16'h0005, 16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0);
        do_op("s_m5_9",  16'hFFFB, 16'h0009, 1'b1, 16'h0000, 16'hFFFB, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
